// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> ISSUE -> CAPTURE -> RESP, with the ALU opcode forced to IDLE_OP between operations.
module alu_arbiter #(
    parameter int         W       = 32,
    parameter logic [3:0] IDLE_OP = 4'b1111
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [3:0]   req_op0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic [3:0]   req_op1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_r,
    output logic         rsp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_r
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_ptr;
    logic           r_grant;
    logic           r_illegal;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [3:0]     r_alu_op;
    logic [W-1:0]   r_rsp_r;
    logic           r_rsp_err;
    logic [1:0]     r_rsp_valid;
    logic [1:0]     w_req_ready;
    logic           w_win;
    logic           w_accept;
    logic           w_rsp_done;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [3:0]     w_sel_op;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // Priority requester wins if valid; otherwise the other one (which may be idle too).
    assign w_win      = req_valid[r_ptr] ? r_ptr : ~r_ptr;
    assign w_accept   = |w_req_ready;
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_grant];
    assign w_sel_a    = w_win ? req_a1  : req_a0;
    assign w_sel_b    = w_win ? req_b1  : req_b0;
    assign w_sel_op   = w_win ? req_op1 : req_op0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    if (w_rsp_done) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 2'b00;
        if (r_state == S_IDLE && |req_valid) begin
            w_req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= 1'b0;
            r_grant     <= 1'b0;
            r_illegal   <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= IDLE_OP;
            r_rsp_r     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= w_sel_a;
                        r_alu_b   <= w_sel_b;
                        r_alu_op  <= w_sel_op;
                        r_grant   <= w_win;
                        r_illegal <= !is_legal(w_sel_op);
                    end
                end
                S_CAPTURE: begin
                    // Illegal ops never expose whatever the ALU produced.
                    r_rsp_r              <= r_illegal ? '0 : alu_r;
                    r_rsp_err            <= r_illegal;
                    r_rsp_valid[r_grant] <= 1'b1;
                    r_alu_op             <= IDLE_OP;
                end
                S_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= 2'b00;
                        r_rsp_err   <= 1'b0;
                        r_ptr       <= ~r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_r     = r_rsp_r;
    assign rsp_err   = r_rsp_err;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit combinational ALU (inputs A, B, OP; output R) between two requesters, e.g. the main datapath and an address/branch-compare unit.
- Arbitration is round-robin. Each requester has a valid/ready request handshake and a valid/ready response handshake.
- The block registers the ALU operands and captures the result one cycle later.
- It forces an OP transition on every operation, because the ALU re-evaluates only when OP changes.

Parameters:
- W, 32, operand/result width; must match the ALU.
- IDLE_OP, 4'b1111, opcode driven to the ALU when no operation is in flight; must not be a legal opcode.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accept.
- req_a0, req_b0  in  W  requester 0 operands.
- req_op0  in  4  requester 0 opcode.
- req_a1, req_b1  in  W  requester 1 operands.
- req_op1  in  4  requester 1 opcode.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_r  out  W  result, shared by both requesters; qualified by rsp_valid.
- rsp_err  out  1  illegal opcode flag, qualified by rsp_valid.
- alu_a, alu_b  out  W  to ALU A, B.
- alu_op  out  4  to ALU OP.
- alu_r  in  W  from ALU R.

Behaviour:
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. All other opcodes are illegal.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, req_ready=00, rsp_valid=00, rsp_r=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_op=IDLE_OP.
  - Round-robin pointer = requester 0 has priority.
  - Reset mid-operation aborts the operation silently: no response, and the handshake is lost.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready is one-hot, combinationally granted to the winner among req_valid bits.
  - Winner = the priority requester if it is valid, else the other requester.
  - No valid requests -> req_ready=00.
  - On the accept edge (req_valid[i] & req_ready[i]):
    - Register operands/op into alu_a, alu_b, alu_op.
    - Record grant i and set the illegal flag.
    - Next state = ISSUE.
  - alu_op must equal IDLE_OP throughout IDLE.
- ISSUE: ALU inputs are stable for one full cycle so the ALU sees the OP change. Next state = CAPTURE. req_ready=00.
- CAPTURE:
  - rsp_r <= alu_r for a legal op; rsp_r <= 0 and rsp_err <= 1 for an illegal op.
  - Set rsp_valid[grant].
  - alu_op <= IDLE_OP.
  - Next state = RESP.
- RESP:
  - Hold rsp_valid, rsp_r and rsp_err stable until rsp_ready[grant]=1.
  - On that edge: clear rsp_valid and rsp_err, move the round-robin pointer to the other requester, next state = IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency: accept edge to rsp_valid high = 2 cycles.
  - Minimum spacing between accepts = 4 cycles: IDLE, ISSUE, CAPTURE, RESP with immediate rsp_ready.
  - No pipelining; exactly one operation in flight.
- Simultaneous requests are served alternately. A requester that holds req_valid must not change its operands or op until it is accepted.
- rsp_r holds its last value after rsp_valid drops.
- Arithmetic is defined entirely by the ALU. The block never modifies alu_r; wrap-around on ADD/SUB is passed through unchanged.
- SLT result: 32'd1 or 32'd0, unsigned compare.

Test Plan:
- Single request: req0 A=5, B=3, op=0010, rsp_ready=1 -> req_ready=01 at the accept cycle; rsp_valid=01 two cycles later with rsp_r=8, rsp_err=0.
- Round-robin: both requesters valid continuously; req0 SUB 10-4, req1 NOR 0,0 -> grant order 0,1,0,1. rsp_r alternates 6 and 32'hFFFFFFFF. The accept edges of successive ops are exactly 4 cycles apart.
- Back-to-back same opcode: req0 AND twice (FFFF0000&0F0F0F0F, then 12345678&FFFFFFFF) -> alu_op returns to 1111 between the two ops. Results are 0F0F0000 and 12345678.
- Response backpressure: req1 ADD FFFFFFFF+1, rsp_ready low for 5 cycles -> rsp_valid=10 with rsp_r=0 held stable for all 5 cycles; req_ready=00 meanwhile.
- Illegal opcode: req0 op=0011 -> rsp_r=0, rsp_err=1. A following legal op clears rsp_err to 0.
- Reset mid-operation: rst_n low during CAPTURE for 1 cycle -> next cycle all outputs are at their reset values and state=IDLE. A new req1 SLT 2<7 then returns rsp_r=1.
